// File: rtl/vga_sprite_compositor_if.sv
// Sprite/background RAM ports, per-sprite position inputs and VGA outputs of the compositor.
// The compositor uses the master side; game logic, RAMs and display sit on the slave side.
interface vga_sprite_compositor_if #(
    parameter int NUM_SPR = 5,
    parameter int ADDR_W  = 10
);
    logic [10*NUM_SPR-1:0]     spr_x;
    logic [10*NUM_SPR-1:0]     spr_y;
    logic [NUM_SPR-1:0]        spr_en;
    logic [ADDR_W*NUM_SPR-1:0] spr_addr;
    logic [9*NUM_SPR-1:0]      spr_data;
    logic [ADDR_W-1:0]         bg_addr;
    logic [8:0]                bg_data;
    logic [2:0]                vgaR;
    logic [2:0]                vgaG;
    logic [2:0]                vgaB;
    logic                      vgaHs;
    logic                      vgaVs;
    logic                      active;
    logic                      frame_start;

    modport master (
        input  spr_x, spr_y, spr_en, spr_data, bg_data,
        output spr_addr, bg_addr, vgaR, vgaG, vgaB, vgaHs, vgaVs, active, frame_start
    );

    modport slave (
        output spr_x, spr_y, spr_en, spr_data, bg_data,
        input  spr_addr, bg_addr, vgaR, vgaG, vgaB, vgaHs, vgaVs, active, frame_start
    );
endinterface

// File: rtl/vga_sprite_compositor.sv
// VGA timing generator compositing NUM_SPR frame-latched sprites over a tiled background.
// Latency: 3 clk from counter value to colour/active/syncs; free-running stream, no backpressure.
module vga_sprite_compositor #(
    parameter int         H_ACTIVE = 640,
    parameter int         H_FP     = 16,
    parameter int         H_SYNC   = 96,
    parameter int         H_BP     = 48,
    parameter int         V_ACTIVE = 480,
    parameter int         V_FP     = 10,
    parameter int         V_SYNC   = 2,
    parameter int         V_BP     = 33,
    parameter bit         SYNC_POL = 1'b0,
    parameter int         NUM_SPR  = 5,
    parameter int         SPR_W    = 32,
    parameter int         SPR_H    = 32,
    parameter int         TILE_W   = 32,
    parameter int         TILE_H   = 32,
    parameter int         ADDR_W   = 10,
    parameter logic [8:0] TRANSP   = 9'h000
) (
    input  logic                   clk,
    input  logic                   rst,
    vga_sprite_compositor_if.master bus
);
    localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
    // 11-bit arithmetic so that sx + SPR_W beyond 1023 clips instead of wrapping.
    localparam int CW    = 11;

    logic [CW-1:0] h_cnt;
    logic [CW-1:0] v_cnt;
    logic          frame_last;

    assign frame_last = (h_cnt == CW'(H_TOT - 1)) && (v_cnt == CW'(V_TOT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == CW'(H_TOT - 1)) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == CW'(V_TOT - 1)) ? '0 : v_cnt + 1'b1;
        end else begin
            h_cnt <= h_cnt + 1'b1;
        end
    end

    logic [10*NUM_SPR-1:0] sh_x;
    logic [10*NUM_SPR-1:0] sh_y;
    logic [NUM_SPR-1:0]    sh_en;
    logic                  frame_start_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_x          <= '0;
            sh_y          <= '0;
            sh_en         <= '0;
            frame_start_q <= 1'b0;
        end else begin
            frame_start_q <= frame_last;
            if (frame_last) begin
                sh_x  <= bus.spr_x;
                sh_y  <= bus.spr_y;
                sh_en <= bus.spr_en;
            end
        end
    end

    logic                      vis_s0, hs_s0, vs_s0;
    logic [NUM_SPR-1:0]        hit_s0;
    logic [ADDR_W*NUM_SPR-1:0] addr_s0;
    logic [ADDR_W-1:0]         bg_addr_s0;
    logic [CW-1:0]             sx, sy, dx, dy;

    assign vis_s0 = (h_cnt < CW'(H_ACTIVE)) && (v_cnt < CW'(V_ACTIVE));
    assign hs_s0  = (h_cnt >= CW'(H_ACTIVE + H_FP)) && (h_cnt < CW'(H_ACTIVE + H_FP + H_SYNC));
    assign vs_s0  = (v_cnt >= CW'(V_ACTIVE + V_FP)) && (v_cnt < CW'(V_ACTIVE + V_FP + V_SYNC));
    assign bg_addr_s0 = ADDR_W'((32'(v_cnt) % 32'(TILE_H)) * 32'(TILE_W)
                                + (32'(h_cnt) % 32'(TILE_W)));

    // Blanking pixels never hit, which also keeps sprite addresses at 0 off-screen.
    always_comb begin
        hit_s0  = '0;
        addr_s0 = '0;
        sx      = '0;
        sy      = '0;
        dx      = '0;
        dy      = '0;
        for (int i = 0; i < NUM_SPR; i++) begin
            sx = {1'b0, sh_x[10*i +: 10]};
            sy = {1'b0, sh_y[10*i +: 10]};
            dx = h_cnt - sx;
            dy = v_cnt - sy;
            hit_s0[i] = sh_en[i] && vis_s0
                        && (h_cnt >= sx) && (h_cnt < sx + CW'(SPR_W))
                        && (v_cnt >= sy) && (v_cnt < sy + CW'(SPR_H));
            if (hit_s0[i]) begin
                addr_s0[ADDR_W*i +: ADDR_W] = ADDR_W'(32'(dy) * 32'(SPR_W) + 32'(dx));
            end
        end
    end

    logic [NUM_SPR-1:0]        hit_d1, hit_d2;
    logic [ADDR_W*NUM_SPR-1:0] addr_d1;
    logic [ADDR_W-1:0]         bg_addr_d1;
    logic                      vis_d1, vis_d2, hs_d1, hs_d2, vs_d1, vs_d2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_d1    <= '0;
            bg_addr_d1 <= '0;
            hit_d1     <= '0;
            hit_d2     <= '0;
            vis_d1     <= 1'b0;
            vis_d2     <= 1'b0;
            hs_d1      <= 1'b0;
            hs_d2      <= 1'b0;
            vs_d1      <= 1'b0;
            vs_d2      <= 1'b0;
        end else begin
            addr_d1    <= addr_s0;
            bg_addr_d1 <= bg_addr_s0;
            hit_d1     <= hit_s0;
            vis_d1     <= vis_s0;
            hs_d1      <= hs_s0;
            vs_d1      <= vs_s0;
            hit_d2     <= hit_d1;
            vis_d2     <= vis_d1;
            hs_d2      <= hs_d1;
            vs_d2      <= vs_d1;
        end
    end

    assign bus.spr_addr = addr_d1;
    assign bus.bg_addr  = bg_addr_d1;

    // Scan from the top index down so the lowest opaque hitting sprite wins.
    logic [8:0] pix_sel;
    always_comb begin
        pix_sel = bus.bg_data;
        for (int i = NUM_SPR - 1; i >= 0; i--) begin
            if (hit_d2[i] && (bus.spr_data[9*i +: 9] != TRANSP)) begin
                pix_sel = bus.spr_data[9*i +: 9];
            end
        end
    end

    logic [8:0] rgb_q;
    logic       act_q, hs_q, vs_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rgb_q <= '0;
            act_q <= 1'b0;
            hs_q  <= ~SYNC_POL;
            vs_q  <= ~SYNC_POL;
        end else begin
            rgb_q <= vis_d2 ? pix_sel : 9'h000;
            act_q <= vis_d2;
            hs_q  <= hs_d2 ? SYNC_POL : ~SYNC_POL;
            vs_q  <= vs_d2 ? SYNC_POL : ~SYNC_POL;
        end
    end

    assign bus.vgaR        = rgb_q[8:6];
    assign bus.vgaG        = rgb_q[5:3];
    assign bus.vgaB        = rgb_q[2:0];
    assign bus.active      = act_q;
    assign bus.vgaHs       = hs_q;
    assign bus.vgaVs       = vs_q;
    assign bus.frame_start = frame_start_q;
endmodule

// File: tb/tb_vga_sprite_compositor.sv
// Scoreboard bench: a pixel-level reference model queues expected outputs, a monitor compares each cycle.
module tb_vga_sprite_compositor;
    localparam int         H_ACTIVE = 64, H_FP = 4, H_SYNC = 8, H_BP = 4;
    localparam int         V_ACTIVE = 24, V_FP = 2, V_SYNC = 2, V_BP = 2;
    localparam int         H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int         V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam bit         SYNC_POL = 1'b0;
    localparam int         NUM_SPR = 3, SPR_W = 8, SPR_H = 8, TILE_W = 8, TILE_H = 8, ADDR_W = 6;
    localparam logic [8:0] TRANSP = 9'h000;
    localparam int         MEM_N = 1 << ADDR_W;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    vga_sprite_compositor_if #(.NUM_SPR(NUM_SPR), .ADDR_W(ADDR_W)) bus ();

    vga_sprite_compositor #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .SYNC_POL(SYNC_POL), .NUM_SPR(NUM_SPR), .SPR_W(SPR_W), .SPR_H(SPR_H),
        .TILE_W(TILE_W), .TILE_H(TILE_H), .ADDR_W(ADDR_W), .TRANSP(TRANSP)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // External 1-cycle-latency RAMs
    logic [8:0] spr_mem [NUM_SPR][MEM_N];
    logic [8:0] bg_mem  [MEM_N];

    always @(posedge clk) begin
        for (int i = 0; i < NUM_SPR; i++)
            bus.spr_data[9*i +: 9] <= spr_mem[i][bus.spr_addr[ADDR_W*i +: ADDR_W]];
        bus.bg_data <= bg_mem[bus.bg_addr];
    end

    typedef struct packed {
        logic [8:0] rgb;
        logic       act;
        logic       hs;
        logic       vs;
    } pix_t;

    typedef struct packed {
        logic [ADDR_W*NUM_SPR-1:0] sa;
        logic [ADDR_W-1:0]         ba;
        logic                      fs;
    } adr_t;

    pix_t pix_q[$];
    adr_t adr_q[$];

    int checks = 0;
    int errors = 0;

    // Reference state: screen position of the current cycle and the frame-latched sprite table.
    int m_h = 0, m_v = 0;
    int sh_x [NUM_SPR];
    int sh_y [NUM_SPR];
    bit sh_en[NUM_SPR];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        pix_t p;
        adr_t a;
        bit   vis, found;
        int   ox, oy;
        vis   = (m_h < H_ACTIVE) && (m_v < V_ACTIVE);
        a     = '0;
        p     = '0;
        found = 1'b0;
        a.ba  = ADDR_W'((m_v % TILE_H) * TILE_W + (m_h % TILE_W));
        a.fs  = (m_h == H_TOT - 1) && (m_v == V_TOT - 1);
        for (int i = 0; i < NUM_SPR; i++) begin
            ox = m_h - sh_x[i];
            oy = m_v - sh_y[i];
            if (vis && sh_en[i] && ox >= 0 && ox < SPR_W && oy >= 0 && oy < SPR_H) begin
                a.sa[ADDR_W*i +: ADDR_W] = ADDR_W'(oy * SPR_W + ox);
                if (!found && spr_mem[i][oy * SPR_W + ox] != TRANSP) begin
                    found = 1'b1;
                    p.rgb = spr_mem[i][oy * SPR_W + ox];
                end
            end
        end
        if (!vis)        p.rgb = 9'h000;
        else if (!found) p.rgb = bg_mem[a.ba];
        p.act = vis;
        p.hs  = (m_h >= H_ACTIVE + H_FP && m_h < H_ACTIVE + H_FP + H_SYNC) ? SYNC_POL : ~SYNC_POL;
        p.vs  = (m_v >= V_ACTIVE + V_FP && m_v < V_ACTIVE + V_FP + V_SYNC) ? SYNC_POL : ~SYNC_POL;
        pix_q.push_back(p);
        adr_q.push_back(a);
        if (a.fs) begin
            for (int i = 0; i < NUM_SPR; i++) begin
                sh_x[i]  = int'(bus.spr_x[10*i +: 10]);
                sh_y[i]  = int'(bus.spr_y[10*i +: 10]);
                sh_en[i] = bus.spr_en[i];
            end
        end
        if (m_h == H_TOT - 1) begin
            m_h = 0;
            m_v = (m_v == V_TOT - 1) ? 0 : m_v + 1;
        end else begin
            m_h = m_h + 1;
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (!rst) model_step();
        end
    end

    // Monitor: one expected entry per cycle, sampled 1 time unit after the rising edge.
    initial begin
        pix_t p;
        adr_t a;
        forever begin
            @(posedge clk);
            #1;
            if (!rst) begin
                if (pix_q.size() == 0 || adr_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL scoreboard_empty: got %0d/%0d entries required >0", pix_q.size(), adr_q.size());
                end else begin
                    p = pix_q.pop_front();
                    a = adr_q.pop_front();
                    check("rgb", {23'd0, bus.vgaR, bus.vgaG, bus.vgaB}, {23'd0, p.rgb});
                    check("active", {31'd0, bus.active}, {31'd0, p.act});
                    check("vgaHs", {31'd0, bus.vgaHs}, {31'd0, p.hs});
                    check("vgaVs", {31'd0, bus.vgaVs}, {31'd0, p.vs});
                    check("spr_addr", 32'(bus.spr_addr), 32'(a.sa));
                    check("bg_addr", 32'(bus.bg_addr), 32'(a.ba));
                    check("frame_start", {31'd0, bus.frame_start}, {31'd0, a.fs});
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #3;
    endtask

    task automatic release_reset();
        pix_t r;
        @(posedge clk);
        #2;
        r     = '0;
        r.hs  = ~SYNC_POL;
        r.vs  = ~SYNC_POL;
        pix_q.delete();
        adr_q.delete();
        pix_q.push_back(r);
        pix_q.push_back(r);
        m_h = 0;
        m_v = 0;
        for (int i = 0; i < NUM_SPR; i++) begin
            sh_x[i]  = 0;
            sh_y[i]  = 0;
            sh_en[i] = 1'b0;
        end
        rst = 1'b0;
    endtask

    task automatic set_spr(input int i, input int x, input int y, input bit en);
        bus.spr_x[10*i +: 10] = 10'(x);
        bus.spr_y[10*i +: 10] = 10'(y);
        bus.spr_en[i]         = en;
    endtask

    task automatic wait_pos(input int th, input int tv);
        int n;
        n = 0;
        do begin
            cyc(1);
            n++;
        end while (!(m_h == th && m_v == tv) && n < H_TOT * V_TOT + 4);
        if (!(m_h == th && m_v == tv)) begin
            checks++;
            errors++;
            $display("FAIL wait_pos: got h=%0d v=%0d required h=%0d v=%0d", m_h, m_v, th, tv);
        end
    endtask

    task automatic mid_reset(input int th, input int tv);
        wait_pos(th, tv);
        rst = 1'b1;
        #1;
        check("rst_rgb", {23'd0, bus.vgaR, bus.vgaG, bus.vgaB}, 32'd0);
        check("rst_active", {31'd0, bus.active}, 32'd0);
        check("rst_vgaHs", {31'd0, bus.vgaHs}, {31'd0, ~SYNC_POL});
        check("rst_vgaVs", {31'd0, bus.vgaVs}, {31'd0, ~SYNC_POL});
        check("rst_frame_start", {31'd0, bus.frame_start}, 32'd0);
        check("rst_spr_addr", 32'(bus.spr_addr), 32'd0);
        repeat (2) @(posedge clk);
        release_reset();
        cyc(1);
    endtask

    initial begin
        int k;
        for (int i = 0; i < NUM_SPR; i++)
            for (int j = 0; j < MEM_N; j++)
                spr_mem[i][j] = ($urandom_range(0, 2) == 0) ? TRANSP : 9'($urandom_range(1, 511));
        for (int j = 0; j < MEM_N; j++) bg_mem[j] = 9'($urandom_range(0, 511));
        spr_mem[0][0]         = 9'h1C0;
        spr_mem[0][MEM_N - 1] = 9'h038;
        bus.spr_x  = '0;
        bus.spr_y  = '0;
        bus.spr_en = '0;

        repeat (3) @(posedge clk);
        release_reset();

        // Line timing from reset release: sync output lags the counter by 3 clocks.
        k = 0;
        while (k < 2 * H_TOT) begin
            @(posedge clk);
            #1;
            k++;
            if (bus.vgaHs === SYNC_POL) break;
        end
        check("first_hsync_clk", 32'(k), 32'(H_ACTIVE + H_FP + 3));
        cyc(1);

        set_spr(0, 10, 5, 1'b1);
        set_spr(1, 14, 7, 1'b1);
        set_spr(2, 40, 10, 1'b1);
        cyc(2 * H_TOT * V_TOT);

        // Stacked and overlapping sprites
        set_spr(0, 20, 12, 1'b1);
        set_spr(1, 20, 12, 1'b1);
        set_spr(2, 22, 14, 1'b1);
        cyc(H_TOT * V_TOT + 50);

        // Mid-frame move must only take effect after the next latch
        wait_pos(5, 13);
        set_spr(0, 30, 12, 1'b1);
        cyc(H_TOT * V_TOT + 100);

        // Right/bottom clipping and a position near the 10-bit limit
        set_spr(0, 60, 3, 1'b1);
        set_spr(1, 1020, 3, 1'b1);
        set_spr(2, 5, 20, 1'b1);
        cyc(H_TOT * V_TOT + 10);

        // Disabled sprite on-screen
        set_spr(0, 10, 10, 1'b0);
        set_spr(1, 30, 10, 1'b1);
        set_spr(2, 12, 12, 1'b0);
        cyc(H_TOT * V_TOT);

        mid_reset(20, 10);
        set_spr(0, 18, 6, 1'b1);
        set_spr(2, 21, 9, 1'b1);
        cyc(H_TOT * V_TOT + 30);

        for (int r = 0; r < 10; r++) begin
            cyc($urandom_range(100, 1500));
            set_spr($urandom_range(0, NUM_SPR - 1),
                    ($urandom_range(0, 9) == 0) ? $urandom_range(1010, 1023) : $urandom_range(0, 70),
                    $urandom_range(0, 31), $urandom_range(0, 3) != 0);
        end

        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < NUM_SPR; i++)
                set_spr(i, $urandom_range(18, 26), $urandom_range(6, 12), 1'b1);
            cyc(H_TOT * V_TOT);
        end

        mid_reset(H_ACTIVE + H_FP + 5, 3);
        cyc(H_TOT * V_TOT + 20);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
